cic_decim_var: RTL and testbench

- Variable-rate CIC decimator that sits directly downstream of the complex CORDIC mixer in the openhpsdr1 receive chain.
- Consumes the mixer's baseband I/Q samples, normally one per clock, and decimates them by a runtime-selectable rate R.
- Emits gain-normalised I/Q with a one-cycle valid strobe to the following FIR and decimation stage.

---
 rtl/cic_pkg.sv | 29 ++
 rtl/cic_rail.sv | 87 ++++++++
 rtl/cic_decim_var.sv | 143 ++++++++++++++
 tb/tb_cic_decim_var.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared sizing and rate helpers for the variable-rate CIC decimator
package cic_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int in_w, input int stages, input int max_rate);
        return in_w + stages * clog2(max_rate);
    endfunction

    // Normalising right shift; the extra output bits beyond the input width are fractional.
    function automatic int shift_for_rate(input int rate, input int stages,
                                          input int in_w, input int out_w);
        return stages * clog2(rate) - (out_w - in_w);
    endfunction

    function automatic int clamp_rate(input int rate, input int max_rate);
        if (rate < 2) return 2;
        if (rate > max_rate) return max_rate;
        return rate;
    endfunction

endpackage

// File: rtl/cic_rail.sv
// rtl/cic_rail.sv - one signed CIC rail: pipelined integrators, token-driven combs, rounding shifter
module cic_rail
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 24,
    parameter int STAGES    = 5,
    parameter int ACC_W     = 58,
    parameter int SHIFT_W   = 7
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        clr,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic        [STAGES-1:0]    integ_en,
    input  logic                        latch_en,
    input  logic        [STAGES-1:0]    comb_en,
    input  logic                        rnd_en,
    input  logic                        out_en,
    input  logic        [SHIFT_W-1:0]   shift,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    typedef logic signed [ACC_W-1:0] acc_t;
    localparam acc_t ACC_ONE = acc_t'(1);

    acc_t integ_q [STAGES];
    acc_t integ_d [STAGES];
    acc_t comb_q  [STAGES];
    acc_t comb_d  [STAGES];
    acc_t prev_q  [STAGES];
    acc_t prev_d  [STAGES];
    acc_t comb_in [STAGES];
    acc_t in_ext;
    acc_t cx_q, cx_d;
    acc_t rnd_q, rnd_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;

    always_comb begin
        in_ext  = {{(ACC_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        integ_d = integ_q;
        if (integ_en[0]) integ_d[0] = integ_q[0] + in_ext;
        // Stage k reads stage k-1 one clock after it advanced for the same sample.
        for (int k = 1; k < STAGES; k++) begin
            if (integ_en[k]) integ_d[k] = integ_q[k] + integ_q[k-1];
        end

        cx_d = latch_en ? integ_q[STAGES-1] : cx_q;

        comb_in[0] = cx_q;
        for (int k = 1; k < STAGES; k++) comb_in[k] = comb_q[k-1];
        comb_d = comb_q;
        prev_d = prev_q;
        for (int k = 0; k < STAGES; k++) begin
            if (comb_en[k]) begin
                comb_d[k] = comb_in[k] - prev_q[k];
                prev_d[k] = comb_in[k];
            end
        end

        rnd_d = rnd_en ? comb_q[STAGES-1] + (ACC_ONE << (shift - SHIFT_W'(1))) : rnd_q;
        out_d = out_en ? OUT_WIDTH'(rnd_q >>> shift) : out_q;
    end

    always_ff @(posedge clock) begin
        if (rst || clr) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                prev_q[k]  <= '0;
            end
            cx_q  <= '0;
            rnd_q <= '0;
            if (rst) out_q <= '0;
        end else begin
            integ_q <= integ_d;
            comb_q  <= comb_d;
            prev_q  <= prev_d;
            cx_q    <= cx_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: rtl/cic_decim_var.sv
// rtl/cic_decim_var.sv - variable-rate I/Q CIC decimator with warm-up suppression and rate-change flush
module cic_decim_var
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 24,
    parameter int STAGES    = 5,
    parameter int MAX_RATE  = 80,
    parameter int RATE_W    = 8
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic        [RATE_W-1:0]    rate,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data_I,
    input  logic signed [IN_WIDTH-1:0]  in_data_Q,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data_I,
    output logic signed [OUT_WIDTH-1:0] out_data_Q
);

    localparam int ACC_W   = acc_width(IN_WIDTH, STAGES, MAX_RATE);
    localparam int SHIFT_W = clog2(ACC_W) + 1;
    localparam int PIPE    = 2 * STAGES + 2;
    localparam int WARM_W  = clog2(STAGES + 1);

    logic [RATE_W-1:0]  r_eff_q, r_eff_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [RATE_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-2:0]  vld_q, vld_d;
    logic [PIPE-1:0]    tag_q, tag_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic               out_valid_q, out_valid_d;

    logic [RATE_W-1:0]  rate_clamped;
    logic [SHIFT_W-1:0] shift_new;
    logic               rate_chg;
    logic               accept;
    logic               tag_new;
    logic               fire;
    logic [STAGES-1:0]  integ_en;

    always_comb begin
        rate_clamped = RATE_W'(clamp_rate(int'(rate), MAX_RATE));
        shift_new    = SHIFT_W'(shift_for_rate(int'(rate_clamped), STAGES, IN_WIDTH, OUT_WIDTH));
        rate_chg     = (rate_clamped != r_eff_q);
        accept       = in_valid && !rate_chg;
        tag_new      = accept && (cnt_q == r_eff_q - RATE_W'(1));
        fire         = tag_q[PIPE-1] && !rate_chg;
        integ_en     = {vld_q, accept};
    end

    // tag_q[k] marks the tagged sample k+1 clocks after its accepting edge.
    always_comb begin
        r_eff_d     = r_eff_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        out_valid_d = 1'b0;
        vld_d[0]    = accept;
        for (int k = 1; k < STAGES - 1; k++) vld_d[k] = vld_q[k-1];
        tag_d[0]    = tag_new;
        for (int k = 1; k < PIPE; k++) tag_d[k] = tag_q[k-1];

        if (rate_chg) begin
            r_eff_d = rate_clamped;
            shift_d = shift_new;
            cnt_d   = '0;
            vld_d   = '0;
            tag_d   = '0;
            warm_d  = WARM_W'(STAGES);
        end else begin
            if (accept) cnt_d = tag_new ? '0 : cnt_q + RATE_W'(1);
            if (fire) begin
                if (warm_q != '0) warm_d = warm_q - WARM_W'(1);
                else              out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_eff_q     <= rate_clamped;
            shift_q     <= shift_new;
            cnt_q       <= '0;
            vld_q       <= '0;
            tag_q       <= '0;
            warm_q      <= WARM_W'(STAGES);
            out_valid_q <= 1'b0;
        end else begin
            r_eff_q     <= r_eff_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            warm_q      <= warm_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    cic_rail #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .STAGES   (STAGES),
        .ACC_W    (ACC_W),
        .SHIFT_W  (SHIFT_W)
    ) u_rail_i (
        .clock   (clock),
        .rst     (rst),
        .clr     (rate_chg),
        .in_data (in_data_I),
        .integ_en(integ_en),
        .latch_en(tag_q[STAGES-1]),
        .comb_en (tag_q[2*STAGES-1:STAGES]),
        .rnd_en  (tag_q[2*STAGES]),
        .out_en  (out_valid_d),
        .shift   (shift_q),
        .out_data(out_data_I)
    );

    cic_rail #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .STAGES   (STAGES),
        .ACC_W    (ACC_W),
        .SHIFT_W  (SHIFT_W)
    ) u_rail_q (
        .clock   (clock),
        .rst     (rst),
        .clr     (rate_chg),
        .in_data (in_data_Q),
        .integ_en(integ_en),
        .latch_en(tag_q[STAGES-1]),
        .comb_en (tag_q[2*STAGES-1:STAGES]),
        .rnd_en  (tag_q[2*STAGES]),
        .out_en  (out_valid_d),
        .shift   (shift_q),
        .out_data(out_data_Q)
    );

endmodule

// File: tb/tb_cic_decim_var.sv
// tb/tb_cic_decim_var.sv - scoreboard bench: convolution model of the CIC response vs DUT strobes
module tb_cic_decim_var;

    localparam int N    = 5;
    localparam int IW   = 23;
    localparam int OW   = 24;
    localparam int RW   = 8;
    localparam int MAXR = 80;
    localparam int LAT  = 2 * N + 2;

    logic          clock = 1'b0;
    logic          rst;
    logic [RW-1:0] rate;
    logic          in_valid;
    logic [IW-1:0] in_data_I, in_data_Q;
    logic          out_valid;
    logic [OW-1:0] out_data_I, out_data_Q;

    always #5 clock = ~clock;

    cic_decim_var #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(N), .MAX_RATE(MAXR), .RATE_W(RW)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .rate      (rate),
        .in_valid  (in_valid),
        .in_data_I (in_data_I),
        .in_data_Q (in_data_Q),
        .out_valid (out_valid),
        .out_data_I(out_data_I),
        .out_data_Q(out_data_Q)
    );

    typedef struct {
        longint ei;
        longint eq;
        int     due;
    } exp_t;

    exp_t   expq[$];
    longint hist_i[$];
    longint hist_q[$];
    longint h[];
    int     m_r, m_cnt, m_tok;
    int     cyc, total, bad;
    int     first_strobe, last_tag_cyc, mark;
    longint last_i, last_q;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int b_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int b_clamp(input int r);
        if (r < 2) return 2;
        if (r > MAXR) return MAXR;
        return r;
    endfunction

    // Impulse response of N cascaded length-r boxcars.
    function automatic void build_h(input int r);
        longint a[];
        longint b[];
        a = new[1];
        a[0] = 1;
        for (int s = 0; s < N; s++) begin
            b = new[a.size() + r - 1];
            foreach (b[i]) b[i] = 0;
            for (int i = 0; i < a.size(); i++)
                for (int j = 0; j < r; j++) b[i+j] += a[i];
            a = b;
        end
        h = a;
    endfunction

    function automatic longint cic_out(input longint hist[$]);
        longint y;
        int     n;
        int     s;
        y = 0;
        n = hist.size();
        for (int k = 0; k < h.size() && k < n; k++) y += h[k] * hist[n-1-k];
        s = N * b_clog2(m_r) - (OW - IW);
        return (y + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    function automatic void model_clear();
        hist_i.delete();
        hist_q.delete();
        expq.delete();
        m_cnt = 0;
        m_tok = 0;
        build_h(m_r);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clock);
        cyc++;
        if (rst) begin
            m_r = b_clamp(int'(rate));
            model_clear();
        end else if (b_clamp(int'(rate)) != m_r) begin
            m_r = b_clamp(int'(rate));
            model_clear();
        end else if (in_valid) begin
            hist_i.push_back(longint'($signed(in_data_I)));
            hist_q.push_back(longint'($signed(in_data_Q)));
            if (hist_i.size() > 500) begin
                void'(hist_i.pop_front());
                void'(hist_q.pop_front());
            end
            if (m_cnt == m_r - 1) begin
                m_cnt = 0;
                last_tag_cyc = cyc;
                if (m_tok >= N) begin
                    e.ei  = cic_out(hist_i);
                    e.eq  = cic_out(hist_q);
                    e.due = cyc + LAT;
                    expq.push_back(e);
                end else begin
                    m_tok++;
                end
            end else begin
                m_cnt++;
            end
        end
        #1;
        if (out_valid) begin
            if (first_strobe < 0) first_strobe = cyc;
            if (expq.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("latency", cyc, e.due);
                chk("out_i", $signed(out_data_I), e.ei);
                chk("out_q", $signed(out_data_Q), e.eq);
                last_i = e.ei;
                last_q = e.eq;
            end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
            chk("missing_strobe", 0, 1);
            void'(expq.pop_front());
        end
    endtask

    // mode 0: dc valid=1, 1: dc toggling, 2: random valid=1, 3: random gapped, 4: idle
    task automatic run(input int n, input int mode, input longint di, input longint dq);
        logic [31:0] r;
        for (int c = 0; c < n; c++) begin
            case (mode)
                0: begin in_valid = 1'b1; in_data_I = di[IW-1:0]; in_data_Q = dq[IW-1:0]; end
                1: begin in_valid = (c % 2 == 0); in_data_I = di[IW-1:0]; in_data_Q = dq[IW-1:0]; end
                2, 3: begin
                    in_valid = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    r = $urandom; in_data_I = r[IW-1:0];
                    r = $urandom; in_data_Q = r[IW-1:0];
                end
                default: in_valid = 1'b0;
            endcase
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        total = 0; bad = 0; cyc = 0;
        first_strobe = -1; last_tag_cyc = -1;
        last_i = 0; last_q = 0;
        m_r = 8;
        rst = 1'b1; rate = 8'd8; in_valid = 1'b0; in_data_I = '0; in_data_Q = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_i", $signed(out_data_I), 0);
        chk("rst_q", $signed(out_data_Q), 0);
        rst = 1'b0;

        // DC at R=8
        first_strobe = -1; mark = cyc + 1;
        run(48 + LAT + 24, 0, 1000, -1000);
        chk("dc8_first", first_strobe, mark + 47 + LAT);
        chk("dc8_i", $signed(out_data_I), 2000);
        chk("dc8_q", $signed(out_data_Q), -2000);

        // DC at R=10 (change edge drops one sample)
        rate = 8'd10; first_strobe = -1; mark = cyc + 2;
        run(1 + 60 + LAT + 20, 0, 1000, 0);
        chk("dc10_first", first_strobe, mark + 59 + LAT);
        chk("dc10_i", $signed(out_data_I), 191);

        // Gapped input at R=8
        rate = 8'd8;
        run(1, 0, 1000, -1000);
        first_strobe = -1; mark = cyc + 1;
        run(2 * 48 + LAT + 40, 1, 1000, -1000);
        chk("gap_first", first_strobe, mark + 94 + LAT);
        chk("gap_i", $signed(out_data_I), 2000);
        chk("gap_q", $signed(out_data_Q), -2000);

        // Full scale at R=MAX_RATE
        rate = 8'd80;
        run(1, 0, 4194303, -4194304);
        run(480 + LAT + 90, 0, 4194303, -4194304);
        chk("fs_i", $signed(out_data_I), 800000);
        chk("fs_q", $signed(out_data_Q), -800000);

        // Rate edges: 0 and 1 both run at 2, above MAX_RATE clamps
        rate = 8'd0;
        run(150, 3, 0, 0);
        rate = 8'd1;
        run(60, 2, 0, 0);
        rate = 8'd200;
        run(520, 2, 0, 0);

        // Rate change two clocks after a tagged accept
        rate = 8'd8;
        run(120, 2, 0, 0);
        g = 0;
        while (last_tag_cyc != cyc && g < 20) begin
            run(1, 2, 0, 0);
            g++;
        end
        chk("rc_tag_found", (last_tag_cyc == cyc), 1);
        run(1, 2, 0, 0);
        rate = 8'd16;
        run(1, 2, 0, 0);
        chk("rc_hold_i", $signed(out_data_I), last_i);
        chk("rc_hold_q", $signed(out_data_Q), last_q);
        first_strobe = -1; mark = cyc + 1;
        run(96 + LAT + 10, 2, 0, 0);
        chk("rc_first", first_strobe, mark + 95 + LAT);

        // Reset while tokens are in flight
        rate = 8'd8;
        run(31, 0, 1000, -1000);
        rst = 1'b1;
        run(1, 0, 1000, -1000);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_i", $signed(out_data_I), 0);
        chk("rst2_q", $signed(out_data_Q), 0);
        last_i = 0; last_q = 0;
        rst = 1'b0;
        first_strobe = -1; mark = cyc + 1;
        run(48 + LAT + 24, 0, 1000, -1000);
        chk("rst2_first", first_strobe, mark + 47 + LAT);
        chk("rst2_dc_i", $signed(out_data_I), 2000);
        chk("rst2_dc_q", $signed(out_data_Q), -2000);

        run(30, 4, 0, 0);
        chk("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
